// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT stage datapath: default widths,
// multiplier latency and the requester-ID tag that rides the multiplier pipe.
package fft_pkg;

  localparam int FFT_N       = 16;
  localparam int FFT_MUL_LAT = 2;
  localparam int REQ_ID_W    = 1;
  localparam int TAG_W       = 1 + REQ_ID_W;

  // Round-robin pointer: which requester wins when both are valid.
  typedef enum logic {
    PTR_REQ0 = 1'b0,
    PTR_REQ1 = 1'b1
  } rr_ptr_e;

endpackage : fft_pkg

// File: rtl/cmult_tag_pipe.sv
// Shift register of {valid,id} tags that mirrors the multiplier pipeline.
// Only the valid bits are reset; ids are don't-care while their valid is 0.
module cmult_tag_pipe
  import fft_pkg::*;
#(
  parameter int DEPTH = FFT_MUL_LAT + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_i,
  input  logic [REQ_ID_W-1:0] id_i,
  output logic                valid_o,
  output logic [REQ_ID_W-1:0] id_o
);

  logic [DEPTH-1:0]    valid_q;
  logic [DEPTH-1:0]    valid_d;
  logic [REQ_ID_W-1:0] id_q [DEPTH];

  // Next valid vector: shift in the new tag at stage 0.
  always_comb begin
    valid_d = {valid_q[DEPTH-2:0], valid_i};
  end

  // Valid bits shift every cycle and are cleared by reset so in-flight results are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Id bits shift alongside the valid bits without reset.
  always_ff @(posedge clk) begin
    id_q[0] <= id_i;
    for (int i = 1; i < DEPTH; i++) begin
      id_q[i] <= id_q[i-1];
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign id_o    = id_q[DEPTH-1];

endmodule : cmult_tag_pipe

// File: rtl/cmult_arbiter.sv
// Shares one fixed-latency pipelined complex multiplier between two requesters.
// Round-robin grant, registered operands, a tag pipe that routes each product
// back to its owner, and an in-flight counter.
//
// RR pointer states:
//   state    | meaning
//   PTR_REQ0 | requester 0 wins the next contended cycle (reset state)
//   PTR_REQ1 | requester 1 wins the next contended cycle
module cmult_arbiter
  import fft_pkg::*;
#(
  parameter int N       = FFT_N,
  parameter int MUL_LAT = FFT_MUL_LAT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [N-1:0] req0_ar,
  input  logic [N-1:0] req0_ai,
  input  logic [N-1:0] req0_br,
  input  logic [N-1:0] req0_bi,
  input  logic [N-1:0] req1_ar,
  input  logic [N-1:0] req1_ai,
  input  logic [N-1:0] req1_br,
  input  logic [N-1:0] req1_bi,
  output logic [N-1:0] mul_ar,
  output logic [N-1:0] mul_ai,
  output logic [N-1:0] mul_br,
  output logic [N-1:0] mul_bi,
  input  logic [N-1:0] mul_cr,
  input  logic [N-1:0] mul_ci,
  output logic [1:0]   res_valid,
  output logic [N-1:0] res_cr,
  output logic [N-1:0] res_ci,
  output logic [2:0]   outstanding,
  output logic         idle
);

  rr_ptr_e             ptr_q, ptr_d;
  logic [1:0]          grant;
  logic                accept;
  logic [REQ_ID_W-1:0] grant_id;

  logic [N-1:0] mul_ar_q, mul_ai_q, mul_br_q, mul_bi_q;
  logic [N-1:0] mul_ar_d, mul_ai_d, mul_br_d, mul_bi_d;

  logic                tag_valid;
  logic [REQ_ID_W-1:0] tag_id;

  logic [1:0]   res_valid_q, res_valid_d;
  logic [N-1:0] res_cr_q, res_cr_d;
  logic [N-1:0] res_ci_q, res_ci_d;

  logic [2:0] outstanding_q, outstanding_d;

  // Grant: a lone requester always wins; contention is settled by the RR pointer.
  // Nothing is granted while reset is held.
  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      if (req_valid == 2'b11) begin
        grant = (ptr_q == PTR_REQ1) ? 2'b10 : 2'b01;
      end else begin
        grant = req_valid;
      end
    end
  end

  assign accept    = |grant;
  assign grant_id  = REQ_ID_W'(grant[1]);
  assign req_ready = grant;

  // Pointer next state and operand mux; the ungranted requester's data is never looked at.
  always_comb begin
    ptr_d    = ptr_q;
    mul_ar_d = mul_ar_q;
    mul_ai_d = mul_ai_q;
    mul_br_d = mul_br_q;
    mul_bi_d = mul_bi_q;
    if (accept) begin
      ptr_d = grant[1] ? PTR_REQ0 : PTR_REQ1;
      if (grant[1]) begin
        mul_ar_d = req1_ar;
        mul_ai_d = req1_ai;
        mul_br_d = req1_br;
        mul_bi_d = req1_bi;
      end else begin
        mul_ar_d = req0_ar;
        mul_ai_d = req0_ai;
        mul_br_d = req0_br;
        mul_bi_d = req0_bi;
      end
    end
  end

  // Pointer and operand registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= PTR_REQ0;
      mul_ar_q <= '0;
      mul_ai_q <= '0;
      mul_br_q <= '0;
      mul_bi_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      mul_ar_q <= mul_ar_d;
      mul_ai_q <= mul_ai_d;
      mul_br_q <= mul_br_d;
      mul_bi_q <= mul_bi_d;
    end
  end

  assign mul_ar = mul_ar_q;
  assign mul_ai = mul_ai_q;
  assign mul_br = mul_br_q;
  assign mul_bi = mul_bi_q;

  // Stage 0 loads on the accept edge; the last stage lines up with mul_cr/ci.
  cmult_tag_pipe #(
    .DEPTH (MUL_LAT + 1)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .valid_i (accept),
    .id_i    (grant_id),
    .valid_o (tag_valid),
    .id_o    (tag_id)
  );

  // Result capture and demux to the owning requester; data holds when nothing returns.
  always_comb begin
    res_valid_d = 2'b00;
    res_cr_d    = res_cr_q;
    res_ci_d    = res_ci_q;
    if (tag_valid) begin
      res_valid_d[tag_id] = 1'b1;
      res_cr_d            = mul_cr;
      res_ci_d            = mul_ci;
    end
  end

  // In-flight count covers the tag pipe plus the return register, so it
  // drops when a result leaves the return register.
  always_comb begin
    outstanding_d = outstanding_q;
    unique case ({accept, |res_valid_q})
      2'b10:   outstanding_d = outstanding_q + 3'd1;
      2'b01:   outstanding_d = outstanding_q - 3'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Result register and in-flight counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid_q   <= 2'b00;
      res_cr_q      <= '0;
      res_ci_q      <= '0;
      outstanding_q <= '0;
    end else begin
      res_valid_q   <= res_valid_d;
      res_cr_q      <= res_cr_d;
      res_ci_q      <= res_ci_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_cr      = res_cr_q;
  assign res_ci      = res_ci_q;
  assign outstanding = outstanding_q;
  assign idle        = (outstanding_q == 3'd0) && !accept;

endmodule : cmult_arbiter
